shift_tx_ctrl: RTL and testbench

- Framing controller that sequences a parallel-load shift register to transmit words serially.
- Accepts a WIDTH-bit word on a valid/ready handshake and emits a frame, LSB first: start bit (0), data bits, optional parity bit, stop bit (1).
- Each bit is held for DIV clock cycles.
- Sits between a word-producing client and a single-wire serial link; one frame in flight at a time.

---
 rtl/shift_ctrl_pkg.sv | 16 +
 rtl/shift_tx_ctrl_if.sv | 31 +++
 rtl/bit_timer.sv | 34 +++
 rtl/shift_tx_ctrl.sv | 150 +++++++++++++++
 tb/tb_shift_tx_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/shift_tx_ctrl_if.sv
// Word handshake plus serial-line status bundle between client and transmitter.
interface shift_tx_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output busy,
    output done
  );

endinterface

// File: rtl/bit_timer.sv
// Free-running divide-by-DIV counter; tick marks the last cycle of each serial bit.
module bit_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // With DIV=1 LAST is 0, so tick is constant and the counter never leaves 0.
  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_tx_ctrl.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define SHIFT_TX_PARITY_EN to insert an even-parity bit between data and stop.
module shift_tx_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input logic           clk,
  input logic           rst_n,
  shift_tx_ctrl_if.slave bus
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             serial_q, serial_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             tick;
`ifdef SHIFT_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign accept = bus.data_valid && ready_q;

  bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        serial_d = IDLE_LEVEL;
        if (accept) begin
          state_d  = START;
          shift_d  = bus.data_in;
          idx_d    = '0;
          serial_d = START_LEVEL;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
          // Parity is taken from the word now because the shift register is consumed.
          parity_d = ^bus.data_in;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          serial_d = shift_q[0];
          idx_d    = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
`ifdef SHIFT_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
`else
            state_d  = STOP;
            serial_d = STOP_LEVEL;
`endif
          end else begin
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
            idx_d    = idx_q + 1'b1;
          end
        end
      end
`ifdef SHIFT_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d  = STOP;
          serial_d = STOP_LEVEL;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d  = IDLE;
          serial_d = IDLE_LEVEL;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = IDLE_LEVEL;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      serial_q <= IDLE_LEVEL;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SHIFT_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.data_ready = ready_q;
  assign bus.serial_out = serial_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl: WIDTH=8/DIV=4 instance plus a WIDTH=4/DIV=1 instance.
module tb_shift_tx_ctrl;

  localparam int unsigned DIV = 4;

`ifdef SHIFT_TX_PARITY_EN
  localparam int unsigned NB  = 11;
  localparam int unsigned NB2 = 7;
  // Hand-computed even parity: A5->0, 07->1, 3C->0, 01->1, 9->0.
  localparam logic [11:0] F_A5 = {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [11:0] F_07 = {1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
  localparam logic [11:0] F_3C = {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
  localparam logic [11:0] F_01 = {1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
  localparam logic [7:0]  F2_9 = {1'b0, 1'b1, 1'b0, 4'h9, 1'b0};
`else
  localparam int unsigned NB  = 10;
  localparam int unsigned NB2 = 6;
  localparam logic [11:0] F_A5 = {2'b00, 1'b1, 8'hA5, 1'b0};
  localparam logic [11:0] F_07 = {2'b00, 1'b1, 8'h07, 1'b0};
  localparam logic [11:0] F_3C = {2'b00, 1'b1, 8'h3C, 1'b0};
  localparam logic [11:0] F_01 = {2'b00, 1'b1, 8'h01, 1'b0};
  // 0x9 -> 0,1,0,0,1,1 on consecutive cycles
  localparam logic [7:0]  F2_9 = 8'b0011_0010;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_tx_ctrl_if #(.WIDTH(8)) m_if ();
  shift_tx_ctrl_if #(.WIDTH(4)) s_if ();

  shift_tx_ctrl #(
    .WIDTH(8),
    .DIV  (DIV)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (m_if.slave)
  );

  shift_tx_ctrl #(
    .WIDTH(4),
    .DIV  (1)
  ) u_dut_div1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (s_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; checks every cycle of the frame and the done cycle.
  task automatic check_frame(input string name, input logic [11:0] f);
    logic [11:0] sh;
    for (int c = 0; c < int'(NB * DIV); c++) begin
      sh = f >> (c / DIV);
      chk($sformatf("%s_c%0d", name, c),
          16'({m_if.serial_out, m_if.data_ready, m_if.busy, m_if.done}),
          16'({sh[0], 3'b010}));
      step();
    end
    chk($sformatf("%s_done", name),
        16'({m_if.serial_out, m_if.data_ready, m_if.busy, m_if.done}), 16'(4'b1101));
  endtask

  task automatic send(input logic [7:0] w);
    m_if.data_in    = w;
    m_if.data_valid = 1'b1;
    step();
    m_if.data_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] sh2;
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    m_if.data_in    = '0;
    m_if.data_valid = 1'b0;
    s_if.data_in    = '0;
    s_if.data_valid = 1'b0;

    step();
    step();
    chk("rst_serial", 16'(m_if.serial_out), 16'(1));
    chk("rst_ready", 16'(m_if.data_ready), 16'(1));
    chk("rst_busy", 16'(m_if.busy), 16'(0));
    chk("rst_done", 16'(m_if.done), 16'(0));
    chk("rst_div1", 16'({s_if.serial_out, s_if.data_ready, s_if.busy, s_if.done}),
        16'(4'b1100));
    rst_n = 1'b1;
    step();
    step();
    chk("idle", 16'({m_if.serial_out, m_if.data_ready, m_if.busy, m_if.done}), 16'(4'b1100));

    // Basic frame and a second data pattern
    send(8'hA5);
    check_frame("a5", F_A5);
    step();
    chk("a5_done_once", 16'(m_if.done), 16'(0));
    step();
    send(8'h07);
    check_frame("x07", F_07);
    step();
    step();

    // Backpressure: 0x3C held valid through the whole 0xA5 frame
    m_if.data_in    = 8'hA5;
    m_if.data_valid = 1'b1;
    step();
    m_if.data_in = 8'h3C;
    check_frame("bp_a5", F_A5);
    step();
    m_if.data_valid = 1'b0;
    check_frame("bp_3c", F_3C);
    step();
    step();

    // Mid-frame reset at T+17 during a 0xFF frame
    send(8'hFF);
    for (int i = 0; i < 16; i++) step();
    chk("ff_mid", 16'({m_if.serial_out, m_if.busy}), 16'(2'b11));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort", 16'({m_if.serial_out, m_if.data_ready, m_if.busy, m_if.done}), 16'(4'b1100));
    for (int i = 0; i < int'(NB * DIV); i++) begin
      chk($sformatf("abort_quiet_%0d", i), 16'({m_if.serial_out, m_if.done}), 16'(2'b10));
      step();
    end
    send(8'h01);
    check_frame("x01", F_01);

    // DIV=1 instance, WIDTH=4
    s_if.data_in    = 4'h9;
    s_if.data_valid = 1'b1;
    step();
    s_if.data_valid = 1'b0;
    for (int c = 0; c < int'(NB2); c++) begin
      sh2 = F2_9 >> c;
      chk($sformatf("div1_c%0d", c),
          16'({s_if.serial_out, s_if.data_ready, s_if.busy, s_if.done}),
          16'({sh2[0], 3'b010}));
      step();
    end
    chk("div1_done", 16'({s_if.serial_out, s_if.data_ready, s_if.busy, s_if.done}),
        16'(4'b1101));
    step();
    chk("div1_done_once", 16'(s_if.done), 16'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
